fpga_tile: RTL and testbench

Parametrised FPGA tile that merges a K-input logic block, input connection muxes and a 4-sided switch box behind a serially loaded configuration chain. It replaces the wide parallel config bus of the first-generation cell with a bit-serial load protocol, generic LUT size and channel width, and a load-complete and error handshake. Tiles are daisy-chained through `cfg_dout` to form the fabric array.

---
 rtl/fpga_tile.sv | 137 +++++++++++++
 tb/tb_fpga_tile.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_tile.sv
// fpga_tile: K-input LUT, input muxes and switch box behind a serial config chain.
// Optional even-parity load check: define FPGA_TILE_CFG_PARITY_EN.
module fpga_tile #(
  parameter int LUT_K  = 4,
  parameter int CHAN_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_en,
  input  logic                  cfg_din,
  output logic                  cfg_dout,
  output logic                  cfg_done,
  output logic                  cfg_err,
  input  logic [4*CHAN_W-1:0]   chan_in,
  output logic [4*CHAN_W-1:0]   chan_out
);

  localparam int NT       = 4 * CHAN_W;
  localparam int S        = $clog2(NT);
  localparam int TT       = 1 << LUT_K;
  localparam int CFG_BITS = TT + 2 + LUT_K * S + 8 * CHAN_W;
`ifdef FPGA_TILE_CFG_PARITY_EN
  localparam int L        = CFG_BITS + 1;
`else
  localparam int L        = CFG_BITS;
`endif
  localparam int CW       = $clog2(L + 2);
  localparam int FFS      = TT;
  localparam int FFI      = TT + 1;
  localparam int PIN_LO   = TT + 2;
  localparam int OSEL_LO  = PIN_LO + LUT_K * S;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SHIFT = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t            state;
  logic [L-1:0]      chain;
  logic [CW-1:0]     cnt;
  logic              ff_q;
  logic [LUT_K-1:0]  pins;
  logic [TT-1:0]     tt;
  logic              lut_out;
  logic              clb_out;
  logic              len_ok;
  logic              load_ok;

  assign cfg_dout = chain[L-1];
  assign tt       = chain[TT-1:0];
  assign lut_out  = tt[pins];
  assign clb_out  = chain[FFS] ? ff_q : lut_out;
  assign len_ok   = (cnt == CW'(L));

`ifdef FPGA_TILE_CFG_PARITY_EN
  assign load_ok  = len_ok && !(^chain);
`else
  assign load_ok  = len_ok;
`endif

  // LUT pin muxes; out-of-range selects read as 0
  always_comb begin
    pins = '0;
    for (int i = 0; i < LUT_K; i++) begin
      if (int'(chain[PIN_LO + i*S +: S]) < NT)
        pins[i] = chan_in[chain[PIN_LO + i*S +: S]];
    end
  end

  // Switch box: per-track source select, gated off outside RUN
  always_comb begin
    chan_out = '0;
    if (state == RUN) begin
      for (int o = 0; o < NT; o++) begin
        case (chain[OSEL_LO + 2*o +: 2])
          2'b01: chan_out[o] = clb_out;
          2'b10: chan_out[o] =
            chan_in[((o / CHAN_W + 2) % 4) * CHAN_W + o % CHAN_W];
          2'b11: chan_out[o] =
            chan_in[((o / CHAN_W + 1) % 4) * CHAN_W + o % CHAN_W];
          default: chan_out[o] = 1'b0;
        endcase
      end
    end
  end

  // Load FSM: shift chain, count bits, length/parity check on cfg_en fall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= EMPTY;
      chain    <= '0;
      cnt      <= '0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      if (cfg_en)
        chain <= {chain[L-2:0], cfg_din};
      case (state)
        EMPTY, RUN: begin
          if (cfg_en) begin
            state    <= SHIFT;
            cnt      <= CW'(1);
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
          end
        end
        SHIFT: begin
          if (cfg_en) begin
            if (cnt != CW'(L + 1))
              cnt <= cnt + CW'(1);
          end else if (load_ok) begin
            state    <= RUN;
            cfg_done <= 1'b1;
          end else begin
            state    <= EMPTY;
            cfg_err  <= 1'b1;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

  // Logic block register: follows LUT in RUN, parked at ff_init otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ff_q <= 1'b0;
    else if (state == RUN)
      ff_q <= lut_out;
    else
      ff_q <= chain[FFI];
  end

endmodule

// File: tb/tb_fpga_tile.sv
// tb_fpga_tile: random and directed loads against a bit-history reference model.
// Parity variant exercised when FPGA_TILE_CFG_PARITY_EN is defined.
module tb_fpga_tile;

  localparam int K  = 4;
  localparam int CW = 2;
  localparam int NT = 4 * CW;
  localparam int S  = 3;
  localparam int TT = 16;
  localparam int CFG_BITS = TT + 2 + K * S + 8 * CW;
`ifdef FPGA_TILE_CFG_PARITY_EN
  localparam int L   = CFG_BITS + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int L   = CFG_BITS;
  localparam bit PAR = 1'b0;
`endif
  localparam int OSEL = TT + 2 + K * S;

  logic clk = 1'b0;
  logic reset;
  logic cfg_en;
  logic cfg_din;
  logic cfg_dout;
  logic cfg_done;
  logic cfg_err;
  logic [NT-1:0] chan_in;
  logic [NT-1:0] chan_out;

  int total = 0;
  int bad   = 0;

  bit          hist[$];
  logic [L-1:0] m_cfg;
  bit          m_run;
  bit          m_err;
  bit          m_ff;

  always #5 clk = ~clk;

  fpga_tile dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_en   (cfg_en),
    .cfg_din  (cfg_din),
    .cfg_dout (cfg_dout),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err),
    .chan_in  (chan_in),
    .chan_out (chan_out)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_lut(logic [L-1:0] c, logic [NT-1:0] ci);
    int idx = 0;
    for (int i = 0; i < K; i++) begin
      int sel = int'(c[TT + 2 + S*i +: S]);
      if (sel < NT && ci[sel]) idx += (1 << i);
    end
    return c[idx];
  endfunction

  function automatic logic [NT-1:0] m_out(logic [L-1:0] c,
                                          logic [NT-1:0] ci,
                                          bit ff, bit run);
    logic [NT-1:0] r = '0;
    bit clb;
    if (!run) return '0;
    clb = c[TT] ? ff : m_lut(c, ci);
    for (int o = 0; o < NT; o++) begin
      int s = o / CW;
      int t = o % CW;
      int code = int'(c[OSEL + 2*o +: 2]);
      case (code)
        1: r[o] = clb;
        2: r[o] = ci[((s + 2) % 4) * CW + t];
        3: r[o] = ci[((s + 1) % 4) * CW + t];
        default: r[o] = 1'b0;
      endcase
    end
    return r;
  endfunction

  function automatic logic [L-1:0] fixpar(logic [L-1:0] w);
    logic [L-1:0] r = w;
    if (PAR) r[L-1] = ^w[L-2:0];
    return r;
  endfunction

  task automatic do_reset();
    reset   = 1'b0;
    cfg_en  = 1'b0;
    cfg_din = 1'b0;
    chan_in = '1;
    #1;
    check("rst_out", chan_out, 0);
    check("rst_done", cfg_done, 0);
    check("rst_err", cfg_err, 0);
    check("rst_dout", cfg_dout, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    hist.delete();
    m_cfg = '0;
    m_run = 1'b0;
    m_err = 1'b0;
    m_ff  = 1'b0;
  endtask

  task automatic shift_bit(bit b);
    cfg_en  = 1'b1;
    cfg_din = b;
    chan_in = NT'($urandom);
    @(posedge clk);
    #1;
    hist.push_back(b);
    m_run = 1'b0;
    m_err = 1'b0;
    check("dout", cfg_dout,
          hist.size() >= L ? 32'(hist[hist.size() - L]) : 0);
    check("done_ld", cfg_done, 0);
    check("err_ld", cfg_err, 0);
    check("out_ld", chan_out, 0);
  endtask

  task automatic load(logic [L+1:0] w, int n);
    bit ok;
    for (int i = n - 1; i >= 0; i--) shift_bit(w[i]);
    cfg_en = 1'b0;
    @(posedge clk);
    #1;
    for (int j = 0; j < L; j++)
      m_cfg[j] = (j < hist.size()) ? hist[hist.size() - 1 - j] : 1'b0;
    ok    = (n == L) && (!PAR || (^m_cfg) == 1'b0);
    m_run = ok;
    m_err = !ok;
    m_ff  = m_cfg[TT + 1];
    check("done", cfg_done, 32'(ok));
    check("err", cfg_err, 32'(!ok));
  endtask

  task automatic run_cycles(int n, logic [NT-1:0] v, bit fixed);
    for (int i = 0; i < n; i++) begin
      chan_in = fixed ? v : NT'($urandom);
      #1;
      check("chan_out", chan_out, m_out(m_cfg, chan_in, m_ff, m_run));
      check("done_run", cfg_done, 32'(m_run));
      check("err_run", cfg_err, 32'(m_err));
      @(posedge clk);
      #1;
      if (m_run) m_ff = m_lut(m_cfg, chan_in);
      else       m_ff = m_cfg[TT + 1];
    end
  endtask

  initial begin
    logic [L-1:0] w;
    logic [L-1:0] and4;
    int n;

    do_reset();

    and4 = '0;
    and4[15] = 1'b1;
    and4[TT + 2 +: 3] = 3'd0;
    and4[TT + 5 +: 3] = 3'd1;
    and4[TT + 8 +: 3] = 3'd2;
    and4[TT + 11 +: 3] = 3'd3;
    and4[OSEL +: 2] = 2'b01;
    and4 = fixpar(and4);
    load(and4, L);
    run_cycles(1, 8'h0F, 1'b1);
    run_cycles(1, 8'h0E, 1'b1);
    run_cycles(4, '0, 1'b0);

    w = and4;
    w[TT] = 1'b1;
    w[TT + 1] = 1'b1;
    w = fixpar(w);
    load(w, L);
    run_cycles(1, 8'h00, 1'b1);
    run_cycles(2, 8'h00, 1'b1);
    run_cycles(2, 8'h0F, 1'b1);
    run_cycles(2, 8'h00, 1'b1);

    load(w, L - 1);
    run_cycles(2, '1, 1'b1);
    load(w, L + 1);
    run_cycles(2, '1, 1'b1);

    w = '0;
    w[OSEL + 2*3 +: 2] = 2'b10;
    w = fixpar(w);
    load(w, L);
    run_cycles(1, 8'h80, 1'b1);
    run_cycles(1, 8'h7F, 1'b1);
    for (int i = 0; i < L; i++) shift_bit(1'($urandom));
    cfg_en = 1'b0;
    @(posedge clk);
    #1;

`ifdef FPGA_TILE_CFG_PARITY_EN
    w = fixpar(and4);
    w[L-1] = ~w[L-1];
    load(w, L);
    run_cycles(1, '1, 1'b1);
    w[L-1] = ~w[L-1];
    load(w, L);
    run_cycles(2, 8'h0F, 1'b1);
`endif

    for (int i = 0; i < 20; i++) shift_bit(1'($urandom));
    do_reset();
    run_cycles(2, '1, 1'b1);

    for (int it = 0; it < 16; it++) begin
      for (int j = 0; j < L; j++) w[j] = 1'($urandom);
      if ($urandom_range(0, 3) != 0) w = fixpar(w);
      case ($urandom_range(0, 5))
        0: n = L - 1;
        1: n = L + 1;
        2: n = $urandom_range(1, L - 2);
        default: n = L;
      endcase
      load({2'($urandom), w}, n);
      run_cycles(8, '0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
